// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_pkg
//  Brief   : Shared types, field indices and helpers for the RTC poll manager.
//  Rev     : 1.0  initial release
// ============================================================================
package rtc_pkg;

    // Default burst geometry of a DS1302-style time block.
    localparam int RTC_N_FIELDS = 7;
    localparam int RTC_FW       = 8;

    // Clock-halt flag lives in the top bit of the seconds byte.
    localparam int CH_BIT = RTC_FW - 1;

    // Field order inside a burst.
    localparam int FLD_SEC   = 0;
    localparam int FLD_MIN   = 1;
    localparam int FLD_HOUR  = 2;
    localparam int FLD_DATE  = 3;
    localparam int FLD_MONTH = 4;
    localparam int FLD_WEEK  = 5;
    localparam int FLD_YEAR  = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_CH   = 3'd1,
        ST_CLEAR_CH  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_READ_TIME = 3'd5
    } rtc_state_e;

    // Extract one field from a packed burst.
    function automatic logic [RTC_FW-1:0] field_get(
        input logic [RTC_N_FIELDS*RTC_FW-1:0] bus,
        input int                              idx
    );
        return bus[idx*RTC_FW +: RTC_FW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_cycle_timer
//  Brief   : Loadable down-counter; expired_o is high while the count is zero.
//  Rev     : 1.0  initial release
// ============================================================================
module rtc_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_poll_mgr.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_poll_mgr
//  Brief   : Schedules RTC transactions for a DS1302-style serial controller:
//            periodic burst poll, clock-halt clearing, queued user writes,
//            validated time snapshot and controller-stall timeout.
//            Optional alarm comparator enabled by macro RTC_ALARM_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module rtc_poll_mgr
    import rtc_pkg::*;
#(
    parameter int N_FIELDS    = RTC_N_FIELDS,
    parameter int FW          = RTC_FW,
    parameter int POLL_CYC    = 5000000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req_i,
    input  logic [N_FIELDS*FW-1:0] wr_data_i,
    output logic                   wr_busy_o,
    output logic                   wr_done_o,
    output logic [N_FIELDS*FW-1:0] rd_data_o,
    output logic                   rd_valid_o,
    output logic                   ch_cleared_o,
    output logic                   err_timeout_o,
    output logic                   ctl_wr_req_o,
    input  logic                   ctl_wr_ack_i,
    output logic [N_FIELDS*FW-1:0] ctl_wr_data_o,
    output logic                   ctl_rd_req_o,
    input  logic                   ctl_rd_ack_i,
    input  logic [N_FIELDS*FW-1:0] ctl_rd_data_i
`ifdef RTC_ALARM_EN
    ,
    input  logic [3*FW-1:0]        alarm_time_i,
    input  logic                   alarm_arm_i,
    output logic                   alarm_irq_o
`endif
);

    localparam int DW     = N_FIELDS * FW;
    localparam int CH_POS = FLD_SEC * FW + (FW - 1);
    localparam int PT_MAX = (POLL_CYC > SETTLE_CYC) ? POLL_CYC : SETTLE_CYC;
    localparam int PTW    = $clog2(PT_MAX + 1);
    localparam int TOW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] CH_MASK = DW'(1) << CH_POS;

    rtc_state_e    state_q;
    logic          ctl_rd_req_q;
    logic          ctl_wr_req_q;
    logic [DW-1:0] ctl_wr_data_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          wr_done_q;
    logic          ch_cleared_q;
    logic          err_q;
    logic          pend_q;
    logic [DW-1:0] pend_buf_q;
    logic          user_wr_q;

    logic           rd_ack_ok;
    logic           wr_ack_ok;
    logic           req_out;
    logic           to_expired;
    logic           timeout_fire;
    logic           pt_expired;
    logic           pt_load;
    logic [PTW-1:0] pt_val;
    logic [DW-1:0]  rd_masked;

    // Acks only count while the matching request is outstanding.
    assign rd_ack_ok    = ctl_rd_req_q & ctl_rd_ack_i;
    assign wr_ack_ok    = ctl_wr_req_q & ctl_wr_ack_i;
    assign req_out      = ctl_rd_req_q | ctl_wr_req_q;
    // An ack arriving on the expiry cycle beats the timeout.
    assign timeout_fire = req_out & ~rd_ack_ok & ~wr_ack_ok & to_expired;
    assign rd_masked    = ctl_rd_data_i & ~CH_MASK;

    // Shared poll/settle timer: settle after any write ack, poll restart at end of poll or timeout.
    always_comb begin
        pt_load = 1'b0;
        pt_val  = PTW'(POLL_CYC - 1);
        if (wr_ack_ok) begin
            pt_load = 1'b1;
            pt_val  = PTW'(SETTLE_CYC - 1);
        end else if (((state_q == ST_READ_TIME) && rd_ack_ok) || timeout_fire) begin
            pt_load = 1'b1;
        end
    end

    rtc_cycle_timer #(.W(PTW)) u_poll_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pt_load),
        .load_val_i (pt_val),
        .expired_o  (pt_expired)
    );

    // Ack timer is held loaded whenever no request is outstanding.
    rtc_cycle_timer #(.W(TOW)) u_ack_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (~req_out),
        .load_val_i (TOW'(TIMEOUT_CYC - 1)),
        .expired_o  (to_expired)
    );

    // Transaction sequencer with registered requests, payload and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ctl_rd_req_q  <= 1'b0;
            ctl_wr_req_q  <= 1'b0;
            ctl_wr_data_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            ch_cleared_q  <= 1'b0;
            err_q         <= 1'b0;
            pend_q        <= 1'b0;
            pend_buf_q    <= '0;
            user_wr_q     <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            ch_cleared_q <= 1'b0;
            // User write stays busy until the cycle after its verifying snapshot.
            if (rd_valid_q) begin
                user_wr_q <= 1'b0;
            end
            if (wr_req_i) begin
                pend_q     <= 1'b1;
                pend_buf_q <= wr_data_i;
            end
            if (rd_ack_ok || wr_ack_ok) begin
                err_q <= 1'b0;
            end
            if (timeout_fire) begin
                ctl_rd_req_q <= 1'b0;
                ctl_wr_req_q <= 1'b0;
                err_q        <= 1'b1;
                user_wr_q    <= 1'b0;
                state_q      <= ST_IDLE;
                // Put an abandoned user write back unless a newer one is already queued.
                if ((state_q == ST_WRITE) && !pend_q && !wr_req_i) begin
                    pend_q     <= 1'b1;
                    pend_buf_q <= ctl_wr_data_q;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q) begin
                            state_q       <= ST_WRITE;
                            ctl_wr_data_q <= pend_buf_q;
                            user_wr_q     <= 1'b1;
                            if (!wr_req_i) begin
                                pend_q <= 1'b0;
                            end
                        end else if (pt_expired) begin
                            state_q <= ST_READ_CH;
                        end
                    end
                    ST_READ_CH: begin
                        if (!ctl_rd_req_q) begin
                            ctl_rd_req_q <= 1'b1;
                        end else if (rd_ack_ok) begin
                            ctl_rd_req_q <= 1'b0;
                            if (ctl_rd_data_i[CH_POS]) begin
                                ctl_wr_data_q <= rd_masked;
                                state_q       <= ST_CLEAR_CH;
                            end else begin
                                state_q <= ST_READ_TIME;
                            end
                        end
                    end
                    ST_CLEAR_CH, ST_WRITE: begin
                        if (!ctl_wr_req_q) begin
                            ctl_wr_req_q <= 1'b1;
                        end else if (wr_ack_ok) begin
                            ctl_wr_req_q <= 1'b0;
                            if (state_q == ST_WRITE) begin
                                wr_done_q <= 1'b1;
                            end else begin
                                ch_cleared_q <= 1'b1;
                            end
                            state_q <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (pt_expired) begin
                            state_q <= ST_READ_TIME;
                        end
                    end
                    ST_READ_TIME: begin
                        if (!ctl_rd_req_q) begin
                            ctl_rd_req_q <= 1'b1;
                        end else if (rd_ack_ok) begin
                            ctl_rd_req_q <= 1'b0;
                            rd_data_q    <= rd_masked;
                            rd_valid_q   <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_busy_o     = pend_q | user_wr_q;
    assign wr_done_o     = wr_done_q;
    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign ch_cleared_o  = ch_cleared_q;
    assign err_timeout_o = err_q;
    assign ctl_wr_req_o  = ctl_wr_req_q;
    assign ctl_wr_data_o = ctl_wr_data_q;
    assign ctl_rd_req_o  = ctl_rd_req_q;

`ifdef RTC_ALARM_EN
    logic [2:0] fld_eq;
    logic       alarm_match;
    logic       match_prev_q;
    logic       alarm_irq_q;

    for (genvar g = 0; g < 3; g++) begin : g_alarm_fld
        logic [FW-1:0] cur_v;
        logic [FW-1:0] ref_v;
        assign cur_v = FW'(field_get(rd_data_q, g));
        assign ref_v = alarm_time_i[g*FW +: FW];
        if (g == FLD_SEC) begin : g_sec
            assign fld_eq[g] = (cur_v[FW-2:0] == ref_v[FW-2:0]);
        end else begin : g_other
            assign fld_eq[g] = (cur_v == ref_v);
        end
    end

    assign alarm_match = &fld_eq;

    // One interrupt per matching second: fire only on a fresh match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_prev_q <= 1'b0;
            alarm_irq_q  <= 1'b0;
        end else begin
            alarm_irq_q <= 1'b0;
            if (!alarm_arm_i) begin
                match_prev_q <= 1'b0;
            end else if (rd_valid_q) begin
                alarm_irq_q  <= alarm_match & ~match_prev_q;
                match_prev_q <= alarm_match;
            end
        end
    end

    assign alarm_irq_o = alarm_irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_poll_mgr.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rtc_poll_mgr
//  Brief   : Directed self-checking bench for rtc_poll_mgr with a controller
//            model that acks after a fixed number of request cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_rtc_poll_mgr;

    localparam int NF      = 7;
    localparam int FW      = 8;
    localparam int DW      = NF * FW;
    localparam int POLL    = 300;
    localparam int TOUT    = 100;
    localparam int SETTLE  = 4;
    localparam int ACK_DLY = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_busy, wr_done, rd_valid, ch_cleared, err_timeout;
    logic [DW-1:0] rd_data, ctl_wr_data;
    logic          ctl_wr_req, ctl_rd_req;
    logic          ctl_wr_ack = 1'b0;
    logic          ctl_rd_ack = 1'b0;
    logic [DW-1:0] ctl_rd_data = '0;
`ifdef RTC_ALARM_EN
    logic [3*FW-1:0] alarm_time = '0;
    logic            alarm_arm = 1'b0;
    logic            alarm_irq;
`endif

    always #5 clk = ~clk;

    rtc_poll_mgr #(
        .N_FIELDS(NF), .FW(FW), .POLL_CYC(POLL), .TIMEOUT_CYC(TOUT), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req_i(wr_req), .wr_data_i(wr_data),
        .wr_busy_o(wr_busy), .wr_done_o(wr_done),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .ch_cleared_o(ch_cleared), .err_timeout_o(err_timeout),
        .ctl_wr_req_o(ctl_wr_req), .ctl_wr_ack_i(ctl_wr_ack), .ctl_wr_data_o(ctl_wr_data),
        .ctl_rd_req_o(ctl_rd_req), .ctl_rd_ack_i(ctl_rd_ack), .ctl_rd_data_i(ctl_rd_data)
`ifdef RTC_ALARM_EN
        , .alarm_time_i(alarm_time), .alarm_arm_i(alarm_arm), .alarm_irq_o(alarm_irq)
`endif
    );

    // ---------------- controller model ----------------
    logic [DW-1:0] rsp_q[$];
    logic [DW-1:0] wlog[$];
    localparam logic [DW-1:0] RSP_DEFAULT = {8'h24, 8'h01, 8'h06, 8'h01, 8'h12, 8'h00, 8'h10};
    bit no_ack = 1'b0;
    int bcnt = 0;

    always @(negedge clk) begin
        ctl_rd_ack = 1'b0;
        ctl_wr_ack = 1'b0;
        if (rst || !(ctl_rd_req || ctl_wr_req)) begin
            bcnt = 0;
        end else begin
            bcnt++;
            if (bcnt >= ACK_DLY && !no_ack) begin
                bcnt = 0;
                if (ctl_rd_req) begin
                    ctl_rd_ack = 1'b1;
                    if (rsp_q.size() > 0) ctl_rd_data = rsp_q.pop_front();
                    else                  ctl_rd_data = RSP_DEFAULT;
                end else begin
                    ctl_wr_ack = 1'b1;
                    wlog.push_back(ctl_wr_data);
                end
            end
        end
    end

    // ---------------- event monitor ----------------
    int cyc = 0, rdv_cnt = 0, wd_cnt = 0, chc_cnt = 0, ctlwr_cyc = 0, both_hi = 0, irq_cnt = 0;
    int last_rdv_cyc = 0, last_wd_cyc = 0, last_ch_cyc = 0, settle_gap = 0;
    logic [DW-1:0] last_rd = '0;
    bit prev_rdv = 1'b0, prev_rdreq = 1'b0;
    logic busy_at_rdv = 1'b0, busy_after_rdv = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rd_valid) begin
            rdv_cnt++;
            last_rd      = rd_data;
            last_rdv_cyc = cyc;
            busy_at_rdv  = wr_busy;
        end
        if (prev_rdv) busy_after_rdv = wr_busy;
        if (wr_done) begin wd_cnt++; last_wd_cyc = cyc; end
        if (ch_cleared) begin chc_cnt++; last_ch_cyc = cyc; end
        if (ctl_rd_req && !prev_rdreq) settle_gap = cyc - last_ch_cyc;
        if (ctl_wr_req) ctlwr_cyc++;
        if (ctl_wr_req && ctl_rd_req) both_hi++;
`ifdef RTC_ALARM_EN
        if (alarm_irq) irq_cnt++;
`endif
        prev_rdv   = rd_valid;
        prev_rdreq = ctl_rd_req;
    end

    // ---------------- helpers ----------------
    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_rdv(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rdv_cnt > base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_req(input bit want_wr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (want_wr ? ctl_wr_req : ctl_rd_req) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_wr(input logic [DW-1:0] d);
        wr_req  = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_req  = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] rd_ch;
        logic [DW-1:0] rd_time;
        bit            exp_clr;
        logic [DW-1:0] exp_wr;
        logic [DW-1:0] exp_rd;
    } vec_t;

    localparam logic [DW-1:0] T1V = {8'h24, 8'h05, 8'h03, 8'h07, 8'h10, 8'h30, 8'h15};
    localparam logic [DW-1:0] W3  = {8'h24, 8'h03, 8'h11, 8'h30, 8'h12, 8'h59, 8'h58};
    localparam logic [DW-1:0] W4A = {8'h25, 8'h12, 8'h31, 8'h06, 8'h23, 8'h59, 8'h50};
    localparam logic [DW-1:0] W4B = {8'h26, 8'h01, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00};

    vec_t vt[4];
    bit   ok;
    int   rb, cb, wb, db, hi_len;

    initial begin
        vt[0] = '{T1V, T1V, 1'b0, '0, T1V};
        vt[1] = '{{8'h24, 8'h05, 8'h03, 8'h07, 8'h10, 8'h31, 8'h95},
                  {8'h24, 8'h05, 8'h03, 8'h07, 8'h10, 8'h31, 8'h16}, 1'b1,
                  {8'h24, 8'h05, 8'h03, 8'h07, 8'h10, 8'h31, 8'h15},
                  {8'h24, 8'h05, 8'h03, 8'h07, 8'h10, 8'h31, 8'h16}};
        vt[2] = '{{8'h99, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h80},
                  {8'h99, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h80}, 1'b1,
                  {8'h99, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h00},
                  {8'h99, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h00}};
        vt[3] = '{{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h7F},
                  {8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h7F}, 1'b0, '0,
                  {8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h7F}};

        // 1: reset state and first immediate poll
        rsp_q.push_back(T1V);
        rsp_q.push_back(T1V);
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctrl outputs", 64'({rd_valid, wr_busy, wr_done, ch_cleared, err_timeout, ctl_wr_req, ctl_rd_req}), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        chk("reset ctl_wr_data", 64'(ctl_wr_data), 64'd0);
        rst = 1'b0;
        wait_rdv(0, 400, ok);
        chk("first poll rd_valid seen", 64'(ok), 64'd1);
        chk("first poll sec", 64'(last_rd[7:0]), 64'h15);
        chk("first poll rd_data", 64'(last_rd), 64'(T1V));
        repeat (5) @(posedge clk);
        #1;
        chk("first poll rd_valid count", 64'(rdv_cnt), 64'd1);
        chk("first poll no ctl_wr_req", 64'(ctlwr_cyc), 64'd0);

        // 2: table of poll responses, with and without clock-halt
        for (int i = 0; i < 4; i++) begin
            rb = rdv_cnt;
            cb = chc_cnt;
            wb = wlog.size();
            rsp_q.push_back(vt[i].rd_ch);
            rsp_q.push_back(vt[i].rd_time);
            wait_rdv(rb, POLL + 400, ok);
            chk($sformatf("vec%0d rd_valid seen", i), 64'(ok), 64'd1);
            chk($sformatf("vec%0d rd_data", i), 64'(last_rd), 64'(vt[i].exp_rd));
            chk($sformatf("vec%0d ch_cleared count", i), 64'(chc_cnt - cb), 64'(vt[i].exp_clr));
            chk($sformatf("vec%0d write count", i), 64'(wlog.size() - wb), 64'(vt[i].exp_clr));
            if (vt[i].exp_clr && wlog.size() > 0) begin
                chk($sformatf("vec%0d clear payload", i), 64'(wlog[wlog.size()-1]), 64'(vt[i].exp_wr));
                // ch_cleared marks settle cycle 1; four settle cycles plus one
                // READ_TIME entry cycle precede the read request.
                chk($sformatf("vec%0d settle gap", i), 64'(settle_gap), 64'(SETTLE + 1));
            end
        end

        // 3: user write during a poll read
        wait_req(1'b0, POLL + 100, ok);
        chk("t3 poll started", 64'(ok), 64'd1);
        rb = rdv_cnt; db = wd_cnt; wb = wlog.size();
        pulse_wr(W3);
        chk("t3 wr_busy after req", 64'(wr_busy), 64'd1);
        wait_rdv(rb, 400, ok);
        chk("t3 poll rd_valid", 64'(ok), 64'd1);
        wait_rdv(rb + 1, 400, ok);
        chk("t3 verify rd_valid", 64'(ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("t3 wr_done count", 64'(wd_cnt - db), 64'd1);
        chk("t3 write count", 64'(wlog.size() - wb), 64'd1);
        if (wlog.size() > wb) chk("t3 payload", 64'(wlog[wb]), 64'(W3));
        chk("t3 wr_done before rd_valid", 64'(last_wd_cyc < last_rdv_cyc), 64'd1);
        chk("t3 busy at rd_valid", 64'(busy_at_rdv), 64'd1);
        chk("t3 busy after rd_valid", 64'(busy_after_rdv), 64'd0);
        chk("t3 busy now", 64'(wr_busy), 64'd0);

        // 4: two writes 5 cycles apart while busy, last one wins
        wait_req(1'b0, POLL + 100, ok);
        chk("t4 poll started", 64'(ok), 64'd1);
        rb = rdv_cnt; db = wd_cnt; wb = wlog.size();
        pulse_wr(W4A);
        repeat (4) @(posedge clk);
        #1;
        pulse_wr(W4B);
        wait_rdv(rb + 1, 800, ok);
        chk("t4 verify rd_valid", 64'(ok), 64'd1);
        chk("t4 wr_done count", 64'(wd_cnt - db), 64'd1);
        chk("t4 write count", 64'(wlog.size() - wb), 64'd1);
        if (wlog.size() > wb) chk("t4 payload", 64'(wlog[wb]), 64'(W4B));

        // 5: controller never acks a poll read
        no_ack = 1'b1;
        rb = rdv_cnt;
        wait_req(1'b0, POLL + 100, ok);
        chk("t5 poll started", 64'(ok), 64'd1);
        hi_len = 1;
        for (int i = 0; i < 3 * TOUT; i++) begin
            @(posedge clk); #1;
            if (ctl_rd_req) hi_len++;
            else break;
        end
        chk("t5 req high length", 64'(hi_len), 64'(TOUT));
        chk("t5 err_timeout set", 64'(err_timeout), 64'd1);
        chk("t5 no rd_valid", 64'(rdv_cnt - rb), 64'd0);
        no_ack = 1'b0;
        wait_rdv(rb, POLL + 400, ok);
        chk("t5 recovery rd_valid", 64'(ok), 64'd1);
        chk("t5 err_timeout cleared", 64'(err_timeout), 64'd0);

`ifdef RTC_ALARM_EN
        // 6: alarm at 12:00:05 fires once on the first matching snapshot
        alarm_time = {8'h12, 8'h00, 8'h05};
        alarm_arm  = 1'b1;
        begin
            logic [7:0] secs[4];
            int         exp_irq[4];
            logic [DW-1:0] v;
            secs = '{8'h04, 8'h05, 8'h05, 8'h06};
            exp_irq = '{0, 1, 1, 1};
            for (int i = 0; i < 4; i++) begin
                v = {8'h24, 8'h05, 8'h03, 8'h07, 8'h12, 8'h00, secs[i]};
                rb = rdv_cnt;
                rsp_q.push_back(v);
                rsp_q.push_back(v);
                wait_rdv(rb, POLL + 400, ok);
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("alarm read%0d irq count", i), 64'(irq_cnt), 64'(exp_irq[i]));
            end
        end
`endif

        // reset asserted in the middle of a write
        pulse_wr(W3);
        wait_req(1'b1, 100, ok);
        chk("rst-mid ctl_wr_req seen", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst-mid ctrl outputs", 64'({rd_valid, wr_busy, wr_done, ch_cleared, err_timeout, ctl_wr_req, ctl_rd_req}), 64'd0);
        chk("rst-mid ctl_wr_data", 64'(ctl_wr_data), 64'd0);
        chk("rst-mid rd_data", 64'(rd_data), 64'd0);
`ifdef RTC_ALARM_EN
        chk("rst-mid alarm_irq", 64'(alarm_irq), 64'd0);
`endif
        chk("rd/wr req never together", 64'(both_hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
